// File: rtl/bfly2_stage_param.sv
// rtl/bfly2_stage_param.sv - radix-2 DIF butterfly stage, 2-deep valid/ready pipeline
// Stage 1 holds exact butterfly results; stage 2 applies optional rounding shift and saturation.
module bfly2_stage_param #(
    parameter int IN_W   = 12,
    parameter int OUT_W  = 13,
    parameter int LANES  = 16,
    parameter int STRIDE = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_inv,
    input  logic                     in_scale,
    input  logic [LANES*IN_W-1:0]    in_re,
    input  logic [LANES*IN_W-1:0]    in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_re,
    output logic [LANES*OUT_W-1:0]   out_im,
    output logic                     sat_sticky,
    output logic [15:0]              sat_cnt,
    input  logic                     sat_clr
);

    localparam int W1 = IN_W + 1;
    localparam int W2 = IN_W + 2;
    localparam int WX = W2 + OUT_W;
    localparam logic signed [W2-1:0] ONE = 1;

    logic signed [W1-1:0]    bf_re [LANES];
    logic signed [W1-1:0]    bf_im [LANES];
    logic signed [W1-1:0]    s1_re_d [LANES];
    logic signed [W1-1:0]    s1_re_q [LANES];
    logic signed [W1-1:0]    s1_im_d [LANES];
    logic signed [W1-1:0]    s1_im_q [LANES];
    logic signed [OUT_W-1:0] sat_re [LANES];
    logic signed [OUT_W-1:0] sat_im [LANES];
    logic signed [OUT_W-1:0] s2_re_d [LANES];
    logic signed [OUT_W-1:0] s2_re_q [LANES];
    logic signed [OUT_W-1:0] s2_im_d [LANES];
    logic signed [OUT_W-1:0] s2_im_q [LANES];
    logic [LANES-1:0]        lane_sat;

    logic        s1_valid_d, s1_valid_q;
    logic        s1_scale_d, s1_scale_q;
    logic        s2_valid_d, s2_valid_q;
    logic        sat_sticky_d, sat_sticky_q;
    logic [15:0] sat_cnt_d, sat_cnt_q;
    logic        s1_adv, s2_adv, sat_ev;

    // Returns {overflow, clamped value}; wide sign extension keeps it valid for any OUT_W.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [W2-1:0] v);
        logic signed [WX-1:0] x;
        logic                 ovf;
        x   = WX'(v);
        ovf = (x[WX-1:OUT_W-1] != {(WX-OUT_W+1){x[WX-1]}});
        if (ovf) sat_fn = {1'b1, x[WX-1], {(OUT_W-1){~x[WX-1]}}};
        else     sat_fn = {1'b0, x[OUT_W-1:0]};
    endfunction

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int POS = l % (2 * STRIDE);
        if (POS < STRIDE) begin : g_sum
            logic signed [IN_W-1:0] a_re, a_im, b_re, b_im;
            assign a_re = in_re[l*IN_W +: IN_W];
            assign a_im = in_im[l*IN_W +: IN_W];
            assign b_re = in_re[(l+STRIDE)*IN_W +: IN_W];
            assign b_im = in_im[(l+STRIDE)*IN_W +: IN_W];
            assign bf_re[l] = {a_re[IN_W-1], a_re} + {b_re[IN_W-1], b_re};
            assign bf_im[l] = {a_im[IN_W-1], a_im} + {b_im[IN_W-1], b_im};
        end else begin : g_diff
            logic signed [IN_W-1:0] a_re, a_im, b_re, b_im;
            logic signed [W1-1:0]   d_re, d_im;
            assign a_re = in_re[(l-STRIDE)*IN_W +: IN_W];
            assign a_im = in_im[(l-STRIDE)*IN_W +: IN_W];
            assign b_re = in_re[l*IN_W +: IN_W];
            assign b_im = in_im[l*IN_W +: IN_W];
            assign d_re = {a_re[IN_W-1], a_re} - {b_re[IN_W-1], b_re};
            assign d_im = {a_im[IN_W-1], a_im} - {b_im[IN_W-1], b_im};
            if (POS >= STRIDE + STRIDE / 2) begin : g_rot
                assign bf_re[l] = in_inv ? -d_im : d_im;
                assign bf_im[l] = in_inv ? d_re  : -d_re;
            end else begin : g_norot
                assign bf_re[l] = d_re;
                assign bf_im[l] = d_im;
            end
        end

        logic signed [W2-1:0] v_re, v_im, r_re, r_im;
        logic [OUT_W:0]       f_re, f_im;
        assign v_re = {s1_re_q[l][W1-1], s1_re_q[l]};
        assign v_im = {s1_im_q[l][W1-1], s1_im_q[l]};
        assign r_re = s1_scale_q ? ((v_re + ONE) >>> 1) : v_re;
        assign r_im = s1_scale_q ? ((v_im + ONE) >>> 1) : v_im;
        assign f_re = sat_fn(r_re);
        assign f_im = sat_fn(r_im);
        assign sat_re[l]   = f_re[OUT_W-1:0];
        assign sat_im[l]   = f_im[OUT_W-1:0];
        assign lane_sat[l] = f_re[OUT_W] | f_im[OUT_W];

        assign out_re[l*OUT_W +: OUT_W] = s2_re_q[l];
        assign out_im[l*OUT_W +: OUT_W] = s2_im_q[l];
    end

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign sat_ev   = s2_adv && s1_valid_q && (|lane_sat);

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_scale_d   = s1_scale_q;
        s1_re_d      = s1_re_q;
        s1_im_d      = s1_im_q;
        s2_valid_d   = s2_valid_q;
        s2_re_d      = s2_re_q;
        s2_im_d      = s2_im_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_scale_d = in_scale;
                s1_re_d    = bf_re;
                s1_im_d    = bf_im;
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_re_d = sat_re;
                s2_im_d = sat_im;
            end
        end
        // Clear first, then a same-cycle event still registers.
        sat_sticky_d = sat_clr ? 1'b0 : sat_sticky_q;
        sat_cnt_d    = sat_clr ? 16'd0 : sat_cnt_q;
        if (sat_ev) begin
            sat_sticky_d = 1'b1;
            if (sat_cnt_d != 16'hFFFF) sat_cnt_d = sat_cnt_d + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q   <= 1'b0;
            s1_scale_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            sat_sticky_q <= 1'b0;
            sat_cnt_q    <= 16'd0;
            for (int l = 0; l < LANES; l++) begin
                s1_re_q[l] <= '0;
                s1_im_q[l] <= '0;
                s2_re_q[l] <= '0;
                s2_im_q[l] <= '0;
            end
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_scale_q   <= s1_scale_d;
            s2_valid_q   <= s2_valid_d;
            sat_sticky_q <= sat_sticky_d;
            sat_cnt_q    <= sat_cnt_d;
            s1_re_q      <= s1_re_d;
            s1_im_q      <= s1_im_d;
            s2_re_q      <= s2_re_d;
            s2_im_q      <= s2_im_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign sat_sticky = sat_sticky_q;
    assign sat_cnt    = sat_cnt_q;

endmodule
